// File: rtl/path_player_pkg.sv
// Shared definitions for path_player: move encoding, FSM states and datapath widths.
package path_player_pkg;

  localparam int unsigned COORD_W = 5;
  localparam int unsigned STEP_W  = 8;

  typedef logic [1:0] move_t;

  // Screen-style axes: "up" decrements y, "down" increments it.
  localparam move_t MV_UP    = 2'b00;
  localparam move_t MV_RIGHT = 2'b01;
  localparam move_t MV_LEFT  = 2'b10;
  localparam move_t MV_DOWN  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    DONE
  } state_t;

endpackage

// File: rtl/path_coord.sv
// Coordinate tracker for path_player: applies accepted moves to (x,y) and flags
// any move that would leave the 0..31 grid (sticky until clr or rst).
module path_coord
  import path_player_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               step,
  input  logic [1:0]         mv,
  output logic [COORD_W-1:0] x_pos,
  output logic [COORD_W-1:0] y_pos,
  output logic               bound_err
);

  logic [COORD_W-1:0] x_nxt;
  logic [COORD_W-1:0] y_nxt;
  logic               oob;

  always_comb begin
    x_nxt = x_pos;
    y_nxt = y_pos;
    oob   = 1'b0;
    unique case (mv)
      MV_UP: begin
        if (y_pos == '0) oob = 1'b1;
        else             y_nxt = y_pos - COORD_W'(1);
      end
      MV_RIGHT: begin
        if (x_pos == '1) oob = 1'b1;
        else             x_nxt = x_pos + COORD_W'(1);
      end
      MV_LEFT: begin
        if (x_pos == '0) oob = 1'b1;
        else             x_nxt = x_pos - COORD_W'(1);
      end
      MV_DOWN: begin
        if (y_pos == '1) oob = 1'b1;
        else             y_nxt = y_pos + COORD_W'(1);
      end
      default: oob = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_pos     <= '0;
      y_pos     <= '0;
      bound_err <= 1'b0;
    end else if (clr) begin
      x_pos     <= '0;
      y_pos     <= '0;
      bound_err <= 1'b0;
    end else if (step) begin
      x_pos <= x_nxt;
      y_pos <= y_nxt;
      if (oob) bound_err <= 1'b1;
    end
  end

endmodule

// File: rtl/path_player.sv
// Plays back the answer stack as a valid/ready move stream, counting accepted moves.
// Define PATH_PLAYER_COORD_EN to build in the coordinate tracker and bound_err.
module path_player
  import path_player_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         stk_data,
  input  logic               stk_empty,
  output logic               stk_pop,
  output logic [1:0]         mv_out,
  output logic               mv_valid,
  input  logic               mv_ready,
  output logic [STEP_W-1:0]  step_cnt,
  output logic               busy,
  output logic               done,
  output logic [COORD_W-1:0] x_pos,
  output logic [COORD_W-1:0] y_pos,
  output logic               bound_err
);

  state_t state;
  state_t state_nxt;
  logic   hs;
  logic   clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stk_pop   = 1'b0;
    mv_valid  = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    clr       = 1'b0;
    hs        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = stk_empty ? DONE : FETCH;
        end
      end
      FETCH: begin
        // Stack drained underneath us: finish rather than pop an empty stack.
        if (stk_empty) begin
          state_nxt = DONE;
        end else begin
          stk_pop   = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        mv_valid = 1'b1;
        if (mv_ready) begin
          hs        = 1'b1;
          state_nxt = stk_empty ? DONE : FETCH;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          mv_out <= '0;
    else if (stk_pop) mv_out <= stk_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         step_cnt <= '0;
    else if (clr)                    step_cnt <= '0;
    else if (hs && step_cnt != '1)   step_cnt <= step_cnt + STEP_W'(1);
  end

`ifdef PATH_PLAYER_COORD_EN
  path_coord u_coord (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .step      (hs),
    .mv        (mv_out),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .bound_err (bound_err)
  );
`else
  assign x_pos     = '0;
  assign y_pos     = '0;
  assign bound_err = 1'b0;
`endif

endmodule

// File: doc/path_player.md
PATH_PLAYER -- requirements
Module: path_player

Interface
REQ-001 The block SHALL have one clock and reset asynchronous active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  level; in IDLE, begins playback of the answer stack.
REQ-005 stk_data  input  2  top-of-answer-stack move, valid while stk_empty=0.
REQ-006 stk_empty  input  1  answer stack empty flag.
REQ-007 stk_pop  output  1  one-cycle pop pulse to the answer stack.
REQ-008 mv_out  output  2  current move presented downstream.
REQ-009 mv_valid  output  1  mv_out valid.
REQ-010 mv_ready  input  1  downstream accepts mv_out.
REQ-011 step_cnt  output  8  moves accepted since the last start.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at end of playback.
REQ-014 x_pos, y_pos  output  5 each  tracked coordinate (only with PATH_PLAYER_COORD_EN).
REQ-015 bound_err  output  1  sticky out-of-range flag (only with PATH_PLAYER_COORD_EN).

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, PRESENT and DONE.
REQ-017 IDLE with start=1 and stk_empty=0 SHALL go to FETCH, and SHALL clear step_cnt, x_pos, y_pos and bound_err.
REQ-018 IDLE with start=1 and stk_empty=1 SHALL go to DONE directly, with step_cnt=0 and stk_pop never asserted.
REQ-019 FETCH SHALL latch stk_data into the move register, assert stk_pop for exactly that cycle, and go to PRESENT (1-cycle latency).
REQ-020 PRESENT SHALL drive mv_valid=1 and hold mv_out stable until the cycle in which mv_ready=1.
REQ-021 A handshake SHALL complete only on the clock edge where mv_valid=1 and mv_ready=1.
REQ-022 mv_ready while not in PRESENT SHALL be ignored.
REQ-023 On handshake, step_cnt SHALL increment, saturating at 255.
REQ-024 On handshake with stk_empty=0, the FSM SHALL go to FETCH.
REQ-025 On handshake with stk_empty=1, the FSM SHALL go to DONE.
REQ-026 DONE SHALL assert done for one cycle and go to IDLE.
REQ-027 step_cnt SHALL hold its value in IDLE until the next start.
REQ-028 stk_pop SHALL never be asserted while stk_empty=1.
REQ-029 start outside IDLE SHALL be ignored.
REQ-030 Move encoding SHALL be: 2'b00 y-1, 2'b01 x+1, 2'b10 x-1, 2'b11 y+1.
REQ-031 With PATH_PLAYER_COORD_EN, on handshake the coordinate SHALL update per REQ-030 using unsigned 5-bit arithmetic.
REQ-032 A move that would decrement below 0 or increment above 31 SHALL leave the coordinate unchanged and set bound_err, which stays set until the next start or rst.
REQ-033 mv_out SHALL reset to 0.
REQ-034 mv_valid, stk_pop, done and busy SHALL be 0 whenever the FSM is in IDLE.

Reset
REQ-035 rst SHALL force IDLE immediately, clear all registers and drive every output to 0, including mid-PRESENT with mv_valid high.
REQ-036 After rst deasserts, the block SHALL wait for a new start; an interrupted playback is not resumed.

Configuration
REQ-037 The macro PATH_PLAYER_COORD_EN SHALL compile the coordinate tracker and bound_err in.
REQ-038 Without PATH_PLAYER_COORD_EN, x_pos, y_pos and bound_err SHALL be tied to 0 and no coordinate logic SHALL be present.
REQ-039 FSM, handshake and step_cnt behaviour SHALL be identical with and without PATH_PLAYER_COORD_EN.

Structure
REQ-040 A shared package SHALL hold the move-encoding constants (MV_UP, MV_RIGHT, MV_LEFT, MV_DOWN), the state encodings, and the widths COORD_W=5 and STEP_W=8.
REQ-041 The coordinate update and bounds check SHALL live in the sub-module path_coord, instantiated only under PATH_PLAYER_COORD_EN.

Verification
REQ-042 Stack holds 01,01,11 (top first), mv_ready=1 constant, start pulse -> mv_out sequence 01,01,11; 3 stk_pop pulses; done one cycle after the last handshake; step_cnt=3; x_pos=2, y_pos=1.
REQ-043 stk_empty=1, start -> done within 2 cycles; stk_pop never high; step_cnt=0.
REQ-044 Stack holds 10, mv_ready held low 5 cycles then high -> mv_out=10 stable with mv_valid=1 for 6 cycles; exactly 1 stk_pop; bound_err=1, x_pos=0.
REQ-045 rst asserted mid-PRESENT with 2 moves remaining -> all outputs 0 in the same cycle; after release, FSM in IDLE and no stk_pop until the next start.
REQ-046 300 moves of alternating 01/10 -> step_cnt saturates at 255; bound_err=0; final x_pos=0.
REQ-047 Build without PATH_PLAYER_COORD_EN, rerun the REQ-042 stimulus -> same mv_out, stk_pop and step_cnt trace; x_pos, y_pos and bound_err remain 0.
